// File: rtl/cmp_seq_pkg.sv
// Package: cmp_seq_pkg
// Shared definitions for the multi-cycle branch comparator and its users
// (the branch decoder reuses the condition codes).
//   cmp_op_e      condition codes carried on ctrl
//   cmp_state_e   comparator FSM states
//   is_signed_op  true for the modes that need the sign bit flipped at capture
//   cond_result   maps the scan outcome (eq, lt) to the branch-taken bit
package cmp_seq_pkg;

    typedef enum logic [2:0] {
        CMP_NONE = 3'b000,
        CMP_EQ   = 3'b001,
        CMP_NE   = 3'b010,
        CMP_LT   = 3'b011,
        CMP_LTU  = 3'b100,
        CMP_GE   = 3'b101,
        CMP_GEU  = 3'b110,
        CMP_RSVD = 3'b111
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } cmp_state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == CMP_LT) || (op == CMP_GE);
    endfunction

    function automatic logic cond_result(input logic [2:0] op,
                                         input logic       eq,
                                         input logic       lt);
        logic r;
        case (op)
            CMP_EQ:          r = eq;
            CMP_NE:          r = ~eq;
            CMP_LT, CMP_LTU: r = lt;
            CMP_GE, CMP_GEU: r = ~lt;
            default:         r = 1'b0;   // 000 and 111 never take the branch
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_seq_if.sv
// Interface: cmp_seq_if
// Request/response handshake between the branch unit and cmp_seq.
//   in_valid/in_ready  request handshake carrying a, b, ctrl
//   out_valid/out_ready response handshake carrying c
// Modports: master = requester/consumer, slave = comparator.
interface cmp_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic             c;

    modport master (
        output in_valid, a, b, ctrl, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, ctrl, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/cmp_chunk.sv
// Module: cmp_chunk
// Combinational unsigned compare of one CHUNK-bit slice.
//   x, y  slice of operand A and operand B
//   eq    x == y
//   lt    x <  y (unsigned)
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             eq,
    output logic             lt
);
    assign eq = (x == y);
    assign lt = (x < y);
endmodule

// File: rtl/cmp_seq.sv
// Module: cmp_seq
// Multi-cycle branch comparator. Scans A and B CHUNK bits per cycle from the
// MSB chunk down, stopping at the first differing chunk, and returns the
// branch-taken bit c over a valid/ready handshake.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   flush  synchronous abort of the operation in flight
//   bus    cmp_seq_if.slave: in_valid/in_ready/a/b/ctrl, out_valid/out_ready/c
module cmp_seq
    import cmp_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    cmp_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    cmp_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    logic [IDX_W-1:0] idx_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             c_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_eq;
    logic             chunk_lt;
    logic             capture;

    // A flush in the same cycle suppresses the capture even though in_ready is high.
    assign capture = (state_q == ST_IDLE) && bus.in_valid && !flush;

    // Select the idx-th chunk of each operand.
    always_comb begin
        // NOTE: defaults first so no path leaves a_chunk/b_chunk unassigned (no latch).
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (a_chunk),
        .y  (b_chunk),
        .eq (chunk_eq),
        .lt (chunk_lt)
    );

    // Operand registers. Flipping the sign bit for LT/GE maps two's-complement
    // ordering onto unsigned ordering, so the scan itself is always unsigned.
    // NOTE: datapath registers carry no reset; they are only read after a capture loads them.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q    <= is_signed_op(bus.ctrl) ? (bus.a ^ SIGN_MASK) : bus.a;
            b_q    <= is_signed_op(bus.ctrl) ? (bus.b ^ SIGN_MASK) : bus.b;
            ctrl_q <= bus.ctrl;
        end
    end

    // Control FSM with registered handshake outputs and result.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= 1'b0;
            idx_q       <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_q    <= ST_SCAN;
                        in_ready_q <= 1'b0;
                        idx_q      <= IDX_W'(NCHUNK - 1);
                    end
                end
                ST_SCAN: begin
                    // On a differing chunk eq=0 and lt comes from the chunk;
                    // on the last equal chunk eq=1 and chunk_lt is already 0.
                    if (!chunk_eq || idx_q == '0) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        c_q         <= cond_result(ctrl_q, chunk_eq, chunk_lt);
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;

endmodule
